// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared state encoding and counter-width helper for the sqrt units
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } sqrt_state_t;

    // Down-counter from n-1 to 0; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one combinational restoring square-root recurrence step
module sqrt_step #(
    parameter int N = 8
) (
    input  logic [N+1:0] rem,
    input  logic [N-1:0] root,
    input  logic [1:0]   top2,
    output logic [N+1:0] rem_nxt,
    output logic [N-1:0] root_nxt
);

    logic [N+3:0] lhs;
    logic [N+3:0] rhs;
    logic [N+4:0] diff;
    logic         borrow;

    assign lhs    = {rem, top2};
    assign rhs    = {2'b00, root, 2'b01};
    assign diff   = {1'b0, lhs} - {1'b0, rhs};
    assign borrow = diff[N+4];

    // Borrow means the trial subtract went negative: keep the shifted remainder.
    assign rem_nxt  = borrow ? (N+2)'(lhs) : (N+2)'(diff);
    assign root_nxt = {root[N-2:0], ~borrow};

endmodule

// File: rtl/sqrt_iter_unit.sv
// rtl/sqrt_iter_unit.sv - iterative integer square root with remainder, handshake and abort
module sqrt_iter_unit
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rstn_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   radicand_i,
    input  logic               abort_i,
    input  logic               ack_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               valid_o,
    output logic [WIDTH/2-1:0] root_o,
    output logic [WIDTH/2:0]   rem_o
);

    localparam int N     = WIDTH / 2;
    localparam int CNT_W = cnt_w(N);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("sqrt_iter_unit: WIDTH must be even and >= 4");
    end

    sqrt_state_t      state;
    sqrt_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] x_sr;
    logic [N+1:0]     rem_q;
    logic [N-1:0]     root_q;
    logic [N+1:0]     rem_nxt;
    logic [N-1:0]     root_nxt;

    sqrt_step #(.N(N)) u_step (
        .rem      (rem_q),
        .root     (root_q),
        .top2     (x_sr[WIDTH-1:WIDTH-2]),
        .rem_nxt  (rem_nxt),
        .root_nxt (root_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = ITER;
            ITER: begin
                if (abort_i)          state_nxt = IDLE;
                else if (cnt == '0)   state_nxt = DONE;
            end
            DONE:    if (ack_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state  <= IDLE;
            cnt    <= '0;
            x_sr   <= '0;
            rem_q  <= '0;
            root_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        x_sr   <= radicand_i;
                        rem_q  <= '0;
                        root_q <= '0;
                        cnt    <= CNT_W'(N - 1);
                    end
                end
                ITER: begin
                    if (!abort_i) begin
                        rem_q  <= rem_nxt;
                        root_q <= root_nxt;
                        x_sr   <= {x_sr[WIDTH-3:0], 2'b00};
                        cnt    <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers hold stale partial values outside DONE, so mask them.
    assign ready_o = (state == IDLE);
    assign busy_o  = (state == ITER) || (state == DONE);
    assign valid_o = (state == DONE);
    assign root_o  = valid_o ? root_q : '0;
    assign rem_o   = valid_o ? (N+1)'(rem_q) : '0;

endmodule

// File: tb/tb_sqrt_iter_unit.sv
// tb/tb_sqrt_iter_unit.sv - scoreboard bench for sqrt_iter_unit at WIDTH=16
module tb_sqrt_iter_unit;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 2;

    logic             clk = 1'b0;
    logic             rstn_i;
    logic             start_i;
    logic [WIDTH-1:0] radicand_i;
    logic             abort_i;
    logic             ack_i;
    logic             ready_o;
    logic             busy_o;
    logic             valid_o;
    logic [N-1:0]     root_o;
    logic [N:0]       rem_o;

    sqrt_iter_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rstn_i     (rstn_i),
        .start_i    (start_i),
        .radicand_i (radicand_i),
        .abort_i    (abort_i),
        .ack_i      (ack_i),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .root_o     (root_o),
        .rem_o      (rem_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] root;
        logic [N:0]   rem;
        int           acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   have_cur   = 1'b0;
    bit   prev_valid = 1'b0;
    bit   mon_en     = 1'b0;
    int   checks     = 0;
    int   errors     = 0;
    int   last_acc   = 0;

    int dx[12] = '{0, 1, 50, 144, 65535, 2, 3, 4, 255, 256, 1000, 65024};
    int dr[12] = '{0, 1, 7,  12,  255,   1, 1, 2, 15,  16,  31,   254};
    int dm[12] = '{0, 0, 1,  0,   510,   1, 2, 0, 30,  0,   39,   508};

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_o && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid_o=1 expected 0 (cycle %0d)", cyc);
                    have_cur = 1'b0;
                end else begin
                    cur      = sb.pop_front();
                    have_cur = 1'b1;
                    check("latency", cyc - cur.acc, N);
                end
            end
            if (valid_o && have_cur) begin
                check("root", root_o, cur.root);
                check("rem", rem_o, cur.rem);
                check("busy_in_done", busy_o, 1);
            end
            if (!valid_o) begin
                check("root_masked", root_o, 0);
                check("rem_masked", rem_o, 0);
                have_cur = 1'b0;
            end
            prev_valid = valid_o;
        end
    end

    task automatic do_op(input logic [WIDTH-1:0] x, input int er, input int erem,
                         input int hold, input bit poke);
        int   n;
        exp_t e;
        n = 0;
        while (!ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_start", ready_o, 1);
        start_i    = 1'b1;
        radicand_i = x;
        e.root     = N'(er);
        e.rem      = (N+1)'(erem);
        e.acc      = cyc + 1;
        last_acc   = e.acc;
        sb.push_back(e);
        @(negedge clk);
        start_i    = poke;
        radicand_i = WIDTH'($urandom);
        n = 0;
        while (!valid_o && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", valid_o, 1);
        repeat (hold) @(negedge clk);
        ack_i = 1'b1;
        @(negedge clk);
        ack_i   = 1'b0;
        start_i = 1'b0;
        check("ack_to_idle", ready_o, 1);
    endtask

    task automatic abort_at(input logic [WIDTH-1:0] x, input int step);
        start_i    = 1'b1;
        radicand_i = x;
        @(negedge clk);
        start_i = 1'b0;
        repeat (step - 1) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_ready", ready_o, 1);
        check("abort_busy", busy_o, 0);
        check("abort_valid", valid_o, 0);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int a;
        int x;
        int r;
        rstn_i     = 1'b0;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        ack_i      = 1'b0;
        radicand_i = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_root", root_o, 0);
        check("rst_rem", rem_o, 0);
        rstn_i = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++)
            do_op(WIDTH'(dx[i]), dr[i], dm[i], (i == 2 || i == 3) ? 5 : 0, (i == 3));

        do_op(WIDTH'(50), 7, 1, 0, 1'b0);
        a = last_acc;
        do_op(WIDTH'(144), 12, 0, 0, 1'b0);
        check("b2b_spacing", last_acc - a, N + 2);

        abort_at(WIDTH'(50), 3);
        do_op(WIDTH'(50), 7, 1, 0, 1'b0);
        abort_at(WIDTH'(65535), N);
        do_op(WIDTH'(144), 12, 0, 0, 1'b0);

        // Reset pulled mid-iteration: nothing was pushed, so any later valid is flagged.
        start_i    = 1'b1;
        radicand_i = WIDTH'(1000);
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        rstn_i = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_ready", ready_o, 1);
        check("midrst_busy", busy_o, 0);
        check("midrst_valid", valid_o, 0);
        check("midrst_root", root_o, 0);
        check("midrst_rem", rem_o, 0);
        rstn_i = 1'b1;
        repeat (12) @(negedge clk);
        do_op(WIDTH'(1000), 31, 39, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            x = int'($urandom_range(0, 65535));
            r = isqrt(x);
            do_op(WIDTH'(x), r, x - r * r, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
